// File: rtl/spi_shift_unit_if.sv
//------------------------------------------------------------------------------
// Module      : spi_shift_unit_if
// Description : Byte handshake between the SPI frame FSM and the shift engine.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface spi_shift_unit_if;
    logic       byte_valid_i;
    logic       byte_ready_o;
    logic [7:0] byte_i;
    logic [1:0] byte_mode_i;
    logic       byte_dir_i;
    logic       rx_valid_o;
    logic [7:0] rx_byte_o;
    logic       busy_o;

    modport slave (
        input  byte_valid_i, byte_i, byte_mode_i, byte_dir_i,
        output byte_ready_o, rx_valid_o, rx_byte_o, busy_o
    );

    modport master (
        output byte_valid_i, byte_i, byte_mode_i, byte_dir_i,
        input  byte_ready_o, rx_valid_o, rx_byte_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/spi_shift_unit.sv
//------------------------------------------------------------------------------
// Module      : spi_shift_unit
// Description : SPI master serial shift engine (SCK generation, 1/2/4 lanes).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_shift_unit (
    input  wire logic       clk_i,
    input  wire logic       rst_n_i,
    input  wire logic       en_i,
    input  wire logic       cpol_i,
    input  wire logic       cpha_i,
    input  wire logic       lsb_i,
    input  wire logic [7:0] div_i,
    spi_shift_unit_if.slave bus,
    output logic            spi_sck_o,
    output logic [3:0]      spi_io_en_o,
    output logic [3:0]      spi_io_out_o,
    input  wire logic [3:0] spi_io_in_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEAD  = 2'd1,
        S_TRAIL = 2'd2
    } state_t;

    localparam logic [1:0] c_MODE_SKIP = 2'd0;
    localparam logic [1:0] c_MODE_STD  = 2'd1;
    localparam logic [1:0] c_MODE_DUAL = 2'd2;
    localparam logic [1:0] c_MODE_QUAD = 2'd3;

    state_t      r_state, w_next;
    logic [15:0] r_cnt;
    logic [2:0]  r_beat;
    logic [1:0]  r_mode;
    logic        r_dir;
    logic [7:0]  r_tx, r_rx, r_rx_byte;
    logic        r_rx_valid, r_sck;
    logic [3:0]  r_io_en, r_io_out;

    logic [3:0]  w_div;
    logic [15:0] w_half_m1;
    logic        w_cnt_done, w_lead_edge, w_trail_edge, w_final;
    logic        w_ready, w_accept, w_start;
    logic [7:0]  w_load, w_rx_shift, w_rx_final;
    logic [3:0]  w_new_en;

    function automatic logic [7:0] f_rev(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    function automatic logic [7:0] f_shl(input logic [7:0] d, input logic [1:0] m);
        case (m)
            c_MODE_DUAL: return {d[5:0], 2'b00};
            c_MODE_QUAD: return {d[3:0], 4'b0000};
            default:     return {d[6:0], 1'b0};
        endcase
    endfunction

    // Earliest bit sits at d[7]; it goes to the highest active lane.
    function automatic logic [3:0] f_top(input logic [7:0] d, input logic [1:0] m);
        case (m)
            c_MODE_DUAL: return {2'b00, d[7:6]};
            c_MODE_QUAD: return d[7:4];
            default:     return {3'b000, d[7]};
        endcase
    endfunction

    function automatic logic [7:0] f_rx_in(input logic [7:0] r, input logic [3:0] in,
                                           input logic [1:0] m);
        case (m)
            c_MODE_DUAL: return {r[5:0], in[1:0]};
            c_MODE_QUAD: return {r[3:0], in};
            default:     return {r[6:0], in[1]};
        endcase
    endfunction

    function automatic logic [3:0] f_en(input logic [1:0] m, input logic dir);
        case (m)
            c_MODE_STD:  return 4'b0001;
            c_MODE_DUAL: return dir ? 4'b0011 : 4'b0000;
            c_MODE_QUAD: return dir ? 4'b1111 : 4'b0000;
            default:     return 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] f_beats_m1(input logic [1:0] m);
        case (m)
            c_MODE_DUAL: return 3'd3;
            c_MODE_QUAD: return 3'd1;
            default:     return 3'd7;
        endcase
    endfunction

    assign w_div      = (div_i > 8'd15) ? 4'd15 : div_i[3:0];
    assign w_half_m1  = (16'd1 << w_div) - 16'd1;
    assign w_cnt_done = (r_cnt == w_half_m1);
    // Bits are kept in wire order; LSB-first is handled by reversing at the byte boundary.
    assign w_load     = lsb_i ? f_rev(bus.byte_i) : bus.byte_i;
    assign w_new_en   = f_en(bus.byte_mode_i, bus.byte_dir_i);
    assign w_rx_shift = f_rx_in(r_rx, spi_io_in_i, r_mode);
    assign w_rx_final = cpha_i ? w_rx_shift : r_rx;

    always_comb begin
        w_next       = r_state;
        w_lead_edge  = 1'b0;
        w_trail_edge = 1'b0;
        w_final      = 1'b0;
        case (r_state)
            S_LEAD: begin
                if (w_cnt_done) begin
                    w_lead_edge = 1'b1;
                    w_next      = S_TRAIL;
                end
            end
            S_TRAIL: begin
                if (w_cnt_done) begin
                    w_trail_edge = 1'b1;
                    if (r_beat == 3'd0) begin
                        w_final = 1'b1;
                        w_next  = S_IDLE;
                    end else begin
                        w_next  = S_LEAD;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
        w_ready  = en_i && ((r_state == S_IDLE) || w_final);
        w_accept = w_ready && bus.byte_valid_i;
        w_start  = w_accept && (bus.byte_mode_i != c_MODE_SKIP);
        if (w_start) w_next = S_LEAD;
        if (!en_i)   w_next = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt      <= 16'd0;
            r_beat     <= 3'd0;
            r_mode     <= c_MODE_SKIP;
            r_dir      <= 1'b0;
            r_tx       <= 8'd0;
            r_rx       <= 8'd0;
            r_rx_byte  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_sck      <= 1'b0;
            r_io_en    <= 4'd0;
            r_io_out   <= 4'd0;
        end else if (!en_i) begin
            r_cnt      <= 16'd0;
            r_rx_valid <= 1'b0;
            r_sck      <= cpol_i;
            r_io_en    <= 4'd0;
            r_io_out   <= 4'd0;
        end else begin
            r_rx_valid <= 1'b0;
            if (r_state == S_IDLE) r_sck <= cpol_i;

            if (w_lead_edge || w_trail_edge) begin
                r_sck <= ~r_sck;
                r_cnt <= 16'd0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if ((w_lead_edge && !cpha_i) || (w_trail_edge && cpha_i))
                r_rx <= w_rx_shift;

            if ((w_lead_edge && cpha_i) || (w_trail_edge && !cpha_i && !w_final)) begin
                r_io_out <= f_top(r_tx, r_mode) & r_io_en;
                r_tx     <= f_shl(r_tx, r_mode);
            end

            if (w_trail_edge) r_beat <= r_beat - 3'd1;

            if (w_final) begin
                r_rx_valid <= (r_mode == c_MODE_STD) || !r_dir;
                r_rx_byte  <= lsb_i ? f_rev(w_rx_final) : w_rx_final;
                r_io_en    <= 4'd0;
                r_io_out   <= 4'd0;
            end

            // A new byte may start on the final trailing edge, so this overrides the above.
            if (w_start) begin
                r_mode  <= bus.byte_mode_i;
                r_dir   <= bus.byte_dir_i;
                r_beat  <= f_beats_m1(bus.byte_mode_i);
                r_cnt   <= 16'd0;
                r_io_en <= w_new_en;
                if (!cpha_i) begin
                    r_io_out <= f_top(w_load, bus.byte_mode_i) & w_new_en;
                    r_tx     <= f_shl(w_load, bus.byte_mode_i);
                end else begin
                    r_io_out <= 4'd0;
                    r_tx     <= w_load;
                end
            end
        end
    end

    assign bus.byte_ready_o = w_ready;
    assign bus.rx_valid_o   = r_rx_valid;
    assign bus.rx_byte_o    = r_rx_byte;
    assign bus.busy_o       = (r_state != S_IDLE);
    assign spi_sck_o        = r_sck;
    assign spi_io_en_o      = r_io_en;
    assign spi_io_out_o     = r_io_out;

endmodule

`default_nettype wire

// File: tb/tb_spi_shift_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_spi_shift_unit
// Description : Directed self-checking bench for spi_shift_unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_shift_unit;

    localparam logic [1:0] c_SKIP = 2'd0;
    localparam logic [1:0] c_STD  = 2'd1;
    localparam logic [1:0] c_DUAL = 2'd2;
    localparam logic [1:0] c_QUAD = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, cpol, cpha, lsb;
    logic [7:0] div;
    logic       sck;
    logic [3:0] io_en, io_out, io_in;

    spi_shift_unit_if bus ();

    spi_shift_unit u_dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .en_i         (en),
        .cpol_i       (cpol),
        .cpha_i       (cpha),
        .lsb_i        (lsb),
        .div_i        (div),
        .bus          (bus.slave),
        .spi_sck_o    (sck),
        .spi_io_en_o  (io_en),
        .spi_io_out_o (io_out),
        .spi_io_in_i  (io_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       sck_l  [0:63];
    logic [3:0] out_l  [0:63];
    logic [3:0] en_l   [0:63];
    logic       rxv_l  [0:63];
    logic [7:0] rxb_l  [0:63];
    logic       busy_l [0:63];
    logic       rdy_l  [0:63];
    logic [3:0] rx_pat [0:7];
    int         h_cur;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic log_cycle(input int c);
        sck_l[c]  = sck;
        out_l[c]  = io_out;
        en_l[c]   = io_en;
        rxv_l[c]  = bus.rx_valid_o;
        rxb_l[c]  = bus.rx_byte_o;
        busy_l[c] = bus.busy_o;
        rdy_l[c]  = bus.byte_ready_o;
    endtask

    // Cycle c: slave data for beat k is presented for the whole 2H window of that beat.
    task automatic tick(input int c);
        int k;
        @(posedge clk);
        #1;
        k = (c - 1) / (2 * h_cur);
        io_in = (k >= 0 && k < 8) ? rx_pat[k] : 4'h0;
        @(negedge clk);
        log_cycle(c);
    endtask

    task automatic run(input int from, input int to);
        for (int c = from; c <= to; c++) tick(c);
    endtask

    task automatic offer(input logic [7:0] b, input logic [1:0] m, input logic d);
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = b;
        bus.byte_mode_i  = m;
        bus.byte_dir_i   = d;
        #1;
        log_cycle(0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_pat();
        for (int i = 0; i < 8; i++) rx_pat[i] = 4'h0;
    endtask

    logic [63:0] v_got, v_exp;
    logic [7:0]  v_pat;

    initial begin
        rst_n = 1'b0; en = 1'b1; cpol = 1'b1; cpha = 1'b0; lsb = 1'b0; div = 8'd0;
        io_in = 4'h0; h_cur = 1;
        bus.byte_valid_i = 1'b0; bus.byte_i = 8'h00; bus.byte_mode_i = c_SKIP; bus.byte_dir_i = 1'b0;
        clear_pat();

        // Reset values
        idle(3);
        chk("rst_sck",   64'(sck), 64'd0);
        chk("rst_io_en", 64'(io_en), 64'd0);
        chk("rst_io_out",64'(io_out), 64'd0);
        chk("rst_rxv",   64'(bus.rx_valid_o), 64'd0);
        chk("rst_rxb",   64'(bus.rx_byte_o), 64'd0);
        chk("rst_busy",  64'(bus.busy_o), 64'd0);
        rst_n = 1'b1;
        idle(2);
        chk("idle_sck_cpol1", 64'(sck), 64'd1);
        cpol = 1'b0;
        idle(2);

        // STD mode 0, div 0, TX 0xA5, slave returns 0x3C on io1
        v_pat = 8'h3C;
        for (int k = 0; k < 8; k++) rx_pat[k] = {2'b00, v_pat[7-k], 1'b0};
        offer(8'hA5, c_STD, 1'b0);
        chk("t1_ready0", 64'(rdy_l[0]), 64'd1);
        tick(1);
        bus.byte_valid_i = 1'b0;
        run(2, 18);
        v_got = '0; v_exp = '0;
        for (int c = 1; c <= 17; c++) begin
            v_got[c] = sck_l[c];
            v_exp[c] = (c >= 2 && c <= 16 && (c % 2) == 0);
        end
        chk("t1_sck", v_got, v_exp);
        v_got = '0;
        for (int k = 0; k < 8; k++) v_got[7-k] = out_l[2*k+1][0];
        chk("t1_io0", v_got, 64'hA5);
        chk("t1_en1",  64'(en_l[1]),  64'b0001);
        chk("t1_en16", 64'(en_l[16]), 64'b0001);
        v_got = '0;
        for (int c = 1; c <= 18; c++) v_got[c] = rxv_l[c];
        chk("t1_rxv", v_got, 64'd1 << 17);
        chk("t1_rxb",    64'(rxb_l[17]), 64'h3C);
        chk("t1_busy1",  64'(busy_l[1]), 64'd1);
        chk("t1_busy17", 64'(busy_l[17]), 64'd0);

        // STD CPOL=1 CPHA=1 LSB=1 div=1, TX 0x01
        cpol = 1'b1; cpha = 1'b1; lsb = 1'b1; div = 8'd1; h_cur = 2;
        clear_pat();
        idle(2);
        chk("t2_idle_sck", 64'(sck), 64'd1);
        offer(8'h01, c_STD, 1'b0);
        tick(1);
        bus.byte_valid_i = 1'b0;
        run(2, 34);
        v_got = '0; v_exp = '0;
        for (int c = 1; c <= 33; c++) begin
            v_got[c] = sck_l[c];
            v_exp[c] = !(c >= 3 && c <= 32 && ((c - 3) % 4) < 2);
        end
        chk("t2_sck", v_got, v_exp);
        v_got = '0;
        for (int k = 0; k < 8; k++) v_got[k] = out_l[3+4*k][0];
        chk("t2_io0", v_got, 64'h01);
        chk("t2_rxv", 64'({rxv_l[32], rxv_l[33]}), 64'b01);
        chk("t2_rxb", 64'(rxb_l[33]), 64'h00);

        // QUAD read, div 0, slave returns 0xA then 0x5
        cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; div = 8'd0; h_cur = 1;
        clear_pat();
        rx_pat[0] = 4'hA; rx_pat[1] = 4'h5;
        idle(1);
        offer(8'h00, c_QUAD, 1'b0);
        tick(1);
        bus.byte_valid_i = 1'b0;
        run(2, 6);
        v_got = '0;
        for (int c = 1; c <= 6; c++) v_got[3:0] = v_got[3:0] | en_l[c];
        chk("t3_en_none", v_got, 64'd0);
        v_got = '0;
        for (int c = 1; c <= 6; c++) if (sck_l[c] && !sck_l[c-1]) v_got++;
        chk("t3_sck_pulses", v_got, 64'd2);
        chk("t3_rxv",   64'(rxv_l[5]), 64'd1);
        chk("t3_rxb",   64'(rxb_l[5]), 64'hA5);
        chk("t3_busy5", 64'(busy_l[5]), 64'd0);

        // Two DUAL writes back to back with valid held
        clear_pat();
        offer(8'h1B, c_DUAL, 1'b1);
        tick(1);
        bus.byte_i = 8'hE4;
        run(2, 9);
        bus.byte_valid_i = 1'b0;
        run(10, 18);
        v_got = '0; v_exp = '0;
        for (int c = 1; c <= 17; c++) begin
            v_got[c] = sck_l[c];
            v_exp[c] = (c >= 2 && c <= 16 && (c % 2) == 0);
        end
        chk("t4_sck", v_got, v_exp);
        v_got = '0;
        for (int k = 0; k < 8; k++) v_got[15-2*k -: 2] = out_l[2*k+1][1:0];
        chk("t4_io", v_got, 64'h1BE4);
        chk("t4_rdy7",  64'(rdy_l[7]), 64'd0);
        chk("t4_rdy8",  64'(rdy_l[8]), 64'd1);
        chk("t4_en9",   64'(en_l[9]), 64'b0011);
        chk("t4_busy9", 64'(busy_l[9]), 64'd1);
        chk("t4_busy17",64'(busy_l[17]), 64'd0);
        v_got = '0;
        for (int c = 1; c <= 18; c++) v_got[0] = v_got[0] | rxv_l[c];
        chk("t4_no_rx", v_got, 64'd0);

        // SKIP byte
        offer(8'hFF, c_SKIP, 1'b0);
        chk("t5_ready0", 64'(rdy_l[0]), 64'd1);
        tick(1);
        bus.byte_valid_i = 1'b0;
        run(2, 5);
        v_got = '0;
        for (int c = 1; c <= 5; c++) v_got[2:0] = v_got[2:0] | {sck_l[c], busy_l[c], rxv_l[c]};
        chk("t5_quiet", v_got, 64'd0);
        chk("t5_ready1", 64'(rdy_l[1]), 64'd1);

        // Abort by en_i at bit 3
        offer(8'hFF, c_STD, 1'b0);
        tick(1);
        bus.byte_valid_i = 1'b0;
        run(2, 7);
        en = 1'b0;
        tick(8);
        chk("t6_sck",   64'(sck_l[8]), 64'd0);
        chk("t6_en",    64'(en_l[8]), 64'd0);
        chk("t6_busy",  64'(busy_l[8]), 64'd0);
        chk("t6_rdy",   64'(rdy_l[8]), 64'd0);
        tick(9);
        en = 1'b1;
        run(10, 20);
        v_got = '0;
        for (int c = 8; c <= 20; c++) v_got[1:0] = v_got[1:0] | {rxv_l[c], busy_l[c]};
        chk("t6_no_rx", v_got, 64'd0);

        // Reset asserted mid-byte
        cpol = 1'b1;
        idle(2);
        offer(8'hC3, c_STD, 1'b0);
        tick(1);
        bus.byte_valid_i = 1'b0;
        run(2, 3);
        chk("t7_pre_busy", 64'(bus.busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_sck",   64'(sck), 64'd0);
        chk("t7_io_en", 64'(io_en), 64'd0);
        chk("t7_io_out",64'(io_out), 64'd0);
        chk("t7_busy",  64'(bus.busy_o), 64'd0);
        chk("t7_rxv",   64'(bus.rx_valid_o), 64'd0);
        chk("t7_rxb",   64'(bus.rx_byte_o), 64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk("t7_sck_after", 64'(sck), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
